// File: rtl/fish_game_sequencer.sv
// fish_game_sequencer: top-level game FSM for the fishing sim.
// It walks fish_controller through the start menu, base play, line reel and
// game finish states, and drives the controller's one-hot q_* inputs.
// It also owns the round countdown timer and freezes the final score.
// Optional feature macro: HIGH_SCORE_EN adds a high_score register and port.
// That register keeps the best final score across rounds until rst.
module fish_game_sequencer #(
  parameter int TICKS_PER_SEC = 60,
  parameter int GAME_SECONDS  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_start,
  input  logic        btn_quit,
  input  logic        fish_hooked,
  input  logic [15:0] score,
  output logic        q_start_menu,
  output logic        q_base_play,
  output logic        q_line_reel,
  output logic        q_game_finish,
  output logic [7:0]  time_left,
  output logic [15:0] final_score
`ifdef HIGH_SCORE_EN
  ,
  output logic [15:0] high_score
`endif
);

  localparam logic [7:0] TICK_MAX  = 8'(TICKS_PER_SEC - 1);
  localparam logic [7:0] GAME_LOAD = 8'(GAME_SECONDS);

  typedef enum logic [1:0] {
    S_START_MENU,
    S_BASE_PLAY,
    S_LINE_REEL,
    S_GAME_FINISH
  } state_t;

  state_t     state;
  state_t     next_state;
  logic       start_prev;
  logic       quit_prev;
  logic       start_e;
  logic       quit_e;
  logic       in_play;
  logic       round_begin;
  logic [7:0] tick_cnt;

  assign start_e     = btn_start & ~start_prev;
  assign quit_e      = btn_quit & ~quit_prev;
  assign in_play     = (state == S_BASE_PLAY) || (state == S_LINE_REEL);
  assign round_begin = (state == S_START_MENU) && start_e;

  // The previous-level registers reset high, so a button held through reset
  // does not look like a fresh press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_prev <= 1'b1;
      quit_prev  <= 1'b1;
    end else begin
      start_prev <= btn_start;
      quit_prev  <= btn_quit;
    end
  end

  // Next-state selection. Quit has top priority in play. A reel that is
  // still in progress keeps the round alive after the timer reaches zero.
  always_comb begin
    next_state = state;
    case (state)
      S_START_MENU: begin
        if (start_e) next_state = S_BASE_PLAY;
      end
      S_BASE_PLAY: begin
        if (quit_e)                 next_state = S_GAME_FINISH;
        else if (time_left == 8'd0) next_state = S_GAME_FINISH;
        else if (fish_hooked)       next_state = S_LINE_REEL;
      end
      S_LINE_REEL: begin
        if (quit_e)                                  next_state = S_GAME_FINISH;
        else if (!fish_hooked && time_left == 8'd0)  next_state = S_GAME_FINISH;
        else if (!fish_hooked)                       next_state = S_BASE_PLAY;
      end
      S_GAME_FINISH: begin
        if (start_e) next_state = S_START_MENU;
      end
      default: next_state = S_START_MENU;
    endcase
  end

  // State register and registered one-hot outputs. The outputs are loaded
  // from the next state, so they always match the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_START_MENU;
      q_start_menu  <= 1'b1;
      q_base_play   <= 1'b0;
      q_line_reel   <= 1'b0;
      q_game_finish <= 1'b0;
    end else begin
      state         <= next_state;
      q_start_menu  <= (next_state == S_START_MENU);
      q_base_play   <= (next_state == S_BASE_PLAY);
      q_line_reel   <= (next_state == S_LINE_REEL);
      q_game_finish <= (next_state == S_GAME_FINISH);
    end
  end

  // Round timer. It is loaded when a round starts and counts down only
  // during play. It saturates at zero, and the sub-second count is held
  // outside play.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      time_left <= 8'd0;
      tick_cnt  <= 8'd0;
    end else if (round_begin) begin
      time_left <= GAME_LOAD;
      tick_cnt  <= 8'd0;
    end else if (in_play && tick) begin
      if (tick_cnt == TICK_MAX) begin
        tick_cnt <= 8'd0;
        if (time_left != 8'd0) time_left <= time_left - 8'd1;
      end else begin
        tick_cnt <= tick_cnt + 8'd1;
      end
    end
  end

  // The final score tracks the live score throughout play, including the
  // edge that enters GAME_FINISH. This lets a catch awarded on that last
  // edge still count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      final_score <= 16'd0;
    end else if (round_begin) begin
      final_score <= 16'd0;
    end else if (in_play) begin
      final_score <= score;
    end
  end

`ifdef HIGH_SCORE_EN
  // The best score is compared once, on the edge that enters GAME_FINISH.
  // It survives across rounds until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_score <= 16'd0;
    end else if (in_play && next_state == S_GAME_FINISH && score > high_score) begin
      high_score <= score;
    end
  end
`endif

endmodule

// File: tb/tb_fish_game_sequencer.sv
// Directed self-checking bench for fish_game_sequencer (TICKS_PER_SEC=4, GAME_SECONDS=3).
// Define HIGH_SCORE_EN on both this file and the RTL to test the high-score register.
module tb_fish_game_sequencer;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        btn_start;
  logic        btn_quit;
  logic        fish_hooked;
  logic [15:0] score;
  logic        q_start_menu;
  logic        q_base_play;
  logic        q_line_reel;
  logic        q_game_finish;
  logic [7:0]  time_left;
  logic [15:0] final_score;
`ifdef HIGH_SCORE_EN
  logic [15:0] high_score;
`endif

  int compared;
  int mismatched;

  localparam logic [3:0] MENU = 4'b1000;
  localparam logic [3:0] PLAY = 4'b0100;
  localparam logic [3:0] REEL = 4'b0010;
  localparam logic [3:0] FIN  = 4'b0001;

  fish_game_sequencer #(.TICKS_PER_SEC(4), .GAME_SECONDS(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .btn_start     (btn_start),
    .btn_quit      (btn_quit),
    .fish_hooked   (fish_hooked),
    .score         (score),
    .q_start_menu  (q_start_menu),
    .q_base_play   (q_base_play),
    .q_line_reel   (q_line_reel),
    .q_game_finish (q_game_finish),
    .time_left     (time_left),
    .final_score   (final_score)
`ifdef HIGH_SCORE_EN
    ,
    .high_score    (high_score)
`endif
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] exp);
    checkOutput(tag, {28'd0, q_start_menu, q_base_play, q_line_reel, q_game_finish}, {28'd0, exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus_tick;
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic applyStimulus_start;
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    step(1);
  endtask

  task automatic applyStimulus_quit;
    btn_quit = 1'b1;
    step(1);
    btn_quit = 1'b0;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    tick        = 1'b0;
    btn_start   = 1'b0;
    btn_quit    = 1'b0;
    fish_hooked = 1'b0;
    score       = 16'd0;
    step(2);
    rst = 1'b0;
    step(1);

    // Reset values
    checkState("reset_state", MENU);
    checkOutput("reset_time", {24'd0, time_left}, 32'd0);
    checkOutput("reset_final", {16'd0, final_score}, 32'd0);
`ifdef HIGH_SCORE_EN
    checkOutput("reset_high", {16'd0, high_score}, 32'd0);
`endif

    // 1. A start press begins the round.
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    checkState("start_to_play", PLAY);
    checkOutput("start_time", {24'd0, time_left}, 32'd3);
    score = 16'd55;
    step(1);
    checkOutput("final_tracks", {16'd0, final_score}, 32'd55);
    score = 16'd0;

    // 2. The countdown runs to zero, then the round finishes.
    for (int i = 1; i <= 12; i++) begin
      applyStimulus_tick;
      if (i % 4 == 0)
        checkOutput($sformatf("countdown_%0d", i), {24'd0, time_left}, 32'(3 - i / 4));
    end
    checkState("play_at_zero", PLAY);
    step(1);
    checkState("timeout_finish", FIN);
    checkOutput("timeout_time", {24'd0, time_left}, 32'd0);
    score = 16'd999;
    applyStimulus_tick;
    checkOutput("finish_time_hold", {24'd0, time_left}, 32'd0);
    checkOutput("finish_final_frozen", {16'd0, final_score}, 32'd0);
    applyStimulus_quit;
    step(1);
    checkState("finish_ignores_quit", FIN);
    applyStimulus_start;
    checkState("finish_to_menu", MENU);
    checkOutput("menu_final_frozen", {16'd0, final_score}, 32'd0);

    // 3. Timer expiry during a reel waits for the reel to resolve.
    score = 16'd10;
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    checkState("round2_play", PLAY);
    checkOutput("round2_final_clear", {16'd0, final_score}, 32'd0);
    fish_hooked = 1'b1;
    step(1);
    checkState("hooked_reel", REEL);
    for (int i = 0; i < 12; i++) applyStimulus_tick;
    checkOutput("reel_time_zero", {24'd0, time_left}, 32'd0);
    step(3);
    checkState("reel_survives_timeout", REEL);
    score = 16'd200;
    fish_hooked = 1'b0;
    step(1);
    checkState("reel_resolve_finish", FIN);
    checkOutput("reel_final_200", {16'd0, final_score}, 32'd200);
`ifdef HIGH_SCORE_EN
    checkOutput("high_after_200", {16'd0, high_score}, 32'd200);
`endif

    // 4. Quit during a reel with time remaining.
    applyStimulus_start;
    checkState("round3_menu", MENU);
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    checkState("round3_play", PLAY);
    fish_hooked = 1'b1;
    step(1);
    checkState("round3_reel", REEL);
    for (int i = 0; i < 4; i++) applyStimulus_tick;
    checkOutput("round3_time_2", {24'd0, time_left}, 32'd2);
    score = 16'd123;
    applyStimulus_quit;
    fish_hooked = 1'b0;
    checkState("quit_reel_finish", FIN);
    checkOutput("quit_final", {16'd0, final_score}, 32'd123);
    checkOutput("quit_time_kept", {24'd0, time_left}, 32'd2);

    // Start wins in the menu, reel returns to play, and quit wins in play.
    applyStimulus_start;
    btn_start = 1'b1;
    btn_quit  = 1'b1;
    step(1);
    btn_start = 1'b0;
    btn_quit  = 1'b0;
    checkState("menu_start_wins", PLAY);
    fish_hooked = 1'b1;
    step(1);
    fish_hooked = 1'b0;
    step(1);
    checkState("reel_back_to_play", PLAY);
    btn_start = 1'b1;
    btn_quit  = 1'b1;
    step(1);
    btn_start = 1'b0;
    btn_quit  = 1'b0;
    checkState("play_quit_wins", FIN);

    // 5. A start held through reset does not fire.
    rst = 1'b1;
    btn_start = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    checkState("held_start_ignored", MENU);
    btn_start = 1'b0;
    step(1);
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    checkState("repress_play", PLAY);
    score = 16'd77;
    step(1);
    checkOutput("midround_final", {16'd0, final_score}, 32'd77);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkState("async_reset_state", MENU);
    checkOutput("async_reset_time", {24'd0, time_left}, 32'd0);
    checkOutput("async_reset_final", {16'd0, final_score}, 32'd0);
    step(1);
    rst = 1'b0;
    step(1);

`ifdef HIGH_SCORE_EN
    // 6. The high score keeps the best result across rounds.
    checkOutput("hs_start", {16'd0, high_score}, 32'd0);
    score = 16'd150;
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    applyStimulus_quit;
    checkOutput("hs_150", {16'd0, high_score}, 32'd150);
    applyStimulus_start;
    score = 16'd75;
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    applyStimulus_quit;
    checkOutput("hs_keeps_150", {16'd0, high_score}, 32'd150);
    applyStimulus_start;
    score = 16'd300;
    btn_start = 1'b1; step(1); btn_start = 1'b0;
    applyStimulus_quit;
    checkOutput("hs_300", {16'd0, high_score}, 32'd300);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("hs_reset", {16'd0, high_score}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
